multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/ctrl_pkg.sv | 65 ++++++
 rtl/cond_unit.sv | 37 +++
 rtl/multicycle_ctrl.sv | 127 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multicycle controller: FSM states, ALU
// select codes, ARM condition codes, instruction classes and the condition check.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags = {N, Z, C, V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~c | z;
      COND_GE: cond_check = ~(n ^ v);
      COND_LT: cond_check = n ^ v;
      COND_GT: cond_check = ~z & ~(n ^ v);
      COND_LE: cond_check = z | (n ^ v);
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Flags register and condition evaluation; cond_q holds the pass/fail of the
// instruction in flight. Built only with MULTICYCLE_CTRL_COND_EXEC_EN, else cond_q=1.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] flag_w,
  input  logic       decode,
  input  logic       execute,
  output logic       cond_q
);

`ifdef MULTICYCLE_CTRL_COND_EXEC_EN
  logic [3:0] flags;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags  <= '0;
      cond_q <= 1'b0;
    end else begin
      if (decode) cond_q <= cond_check(Cond, flags);
      if (execute && cond_q) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end
`else
  logic unused_cond;
  assign unused_cond = ^{clk, reset, Cond, ALUFlags, flag_w, decode, execute};
  assign cond_q      = 1'b1;
`endif

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle ARM-subset control unit: Moore FSM, ALU decode and write gating.
// Conditional execution is enabled by defining MULTICYCLE_CTRL_COND_EXEC_EN.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc
);

  state_t     state, state_n;
  logic       run;
  logic       irw, nextpc, regw, memw, branch, aluop, pcs, cond_q;
  logic [1:0] flag_w;

  // run is cleared asynchronously by reset and set on the first edge after
  // release, so FETCH is held one edge and all enables are masked in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      run   <= 1'b0;
    end else begin
      state <= state_n;
      run   <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      FETCH:    if (run) state_n = DECODE;
      DECODE: begin
        case (Op)
          OP_MEM:  state_n = MEMADR;
          OP_DP:   state_n = Funct[5] ? EXECUTEI : EXECUTER;
          OP_BR:   state_n = BRANCH;
          default: state_n = FETCH;
        endcase
      end
      MEMADR:   state_n = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_n = MEMWB;
      EXECUTER: state_n = ALUWB;
      EXECUTEI: state_n = ALUWB;
      default:  state_n = FETCH;
    endcase
  end

  always_comb begin
    irw       = 1'b0;
    nextpc    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    branch    = 1'b0;
    aluop     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        irw = 1'b1; nextpc = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWB:    begin ResultSrc = 2'b01; regw = 1'b1; end
      MEMWRITE: begin AdrSrc = 1'b1; memw = 1'b1; end
      EXECUTER: aluop = 1'b1;
      EXECUTEI: begin ALUSrcB = 2'b01; aluop = 1'b1; end
      ALUWB:    regw = 1'b1;
      BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = '0;
    if (aluop) begin
      case (Funct[4:1])
        CMD_SUB: ALUControl = ALU_SUB;
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] & ((Funct[4:1] == CMD_ADD) | (Funct[4:1] == CMD_SUB));
    end
  end

  cond_unit u_cond (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .flag_w   (flag_w),
    .decode   (state == DECODE),
    .execute  ((state == EXECUTER) || (state == EXECUTEI)),
    .cond_q   (cond_q)
  );

  assign pcs      = ((Rd == 4'hF) & regw) | branch;
  assign PCWrite  = run & (nextpc | (pcs & cond_q));
  assign IRWrite  = run & irw;
  assign RegWrite = run & regw & cond_q;
  assign MemWrite = run & memw & cond_q;
  assign ImmSrc   = Op;
  assign RegSrc   = {(Op == OP_MEM) & ~Funct[0], Op == OP_BR};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions plus random
// instruction streams against a per-instruction phase model.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc)
  );

  always #5 clk = ~clk;

`ifdef MULTICYCLE_CTRL_COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_EX, P_WB, P_BR} phase_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [3:0]  m_flags = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // {PCWrite,IRWrite,MemWrite,RegWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc,RegSrc}
  function automatic logic [15:0] expect_vec(input phase_t p, input logic ex, input logic [1:0] o,
                                             input logic [5:0] f, input logic [3:0] r);
    logic       pcw, irw, mw, rw, adr, srca;
    logic [1:0] srcb, res, alu;
    pcw  = (p == P_F) || (((p == P_MWB) || (p == P_WB)) && ex && (r == 4'd15)) || ((p == P_BR) && ex);
    irw  = (p == P_F);
    mw   = (p == P_MW) && ex;
    rw   = ((p == P_MWB) || (p == P_WB)) && ex;
    adr  = (p == P_MR) || (p == P_MW);
    srca = (p == P_F) || (p == P_D);
    srcb = ((p == P_F) || (p == P_D)) ? 2'd2 :
           ((p == P_MA) || (p == P_BR) || ((p == P_EX) && f[5])) ? 2'd1 : 2'd0;
    res  = ((p == P_F) || (p == P_D) || (p == P_BR)) ? 2'd2 : (p == P_MWB) ? 2'd1 : 2'd0;
    alu  = 2'd0;
    if (p == P_EX) begin
      if (f[4:1] == 4'b0010) alu = 2'd1;
      else if (f[4:1] == 4'b0000) alu = 2'd2;
      else if (f[4:1] == 4'b1100) alu = 2'd3;
    end
    return {pcw, irw, mw, rw, adr, srca, srcb, res, alu, o, (o == 2'b01) && !f[0], o == 2'b10};
  endfunction

  function automatic logic [15:0] observed();
    return {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            ALUControl, ImmSrc, RegSrc};
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hold_en", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
    reset = 1'b1;
    #1;
    check("rst_release_irw", {31'd0, IRWrite}, 32'd0);
    m_flags = '0;
    @(posedge clk);
    #1;
  endtask

  // Called just after the edge that enters FETCH; returns just after the edge
  // that enters the next FETCH. abort_at >= 0 asserts reset in that phase.
  task automatic run_instr(input string name, input logic [3:0] c, input logic [1:0] o,
                           input logic [5:0] f, input logic [3:0] r, input bit use_fixed,
                           input logic [3:0] af_fixed, input int abort_at);
    phase_t     ph[$];
    logic       ex;
    logic [3:0] af;
    Cond = c; Op = o; Funct = f; Rd = r;
    ex = COND_EN ? cond_holds(c, m_flags) : 1'b1;
    ph = '{P_F, P_D};
    case (o)
      2'b00: begin ph.push_back(P_EX); ph.push_back(P_WB); end
      2'b01: begin
        ph.push_back(P_MA);
        if (f[0]) begin ph.push_back(P_MR); ph.push_back(P_MWB); end
        else ph.push_back(P_MW);
      end
      2'b10: ph.push_back(P_BR);
      default: ;
    endcase
    foreach (ph[i]) begin
      af = use_fixed ? af_fixed : 4'($urandom);
      ALUFlags = af;
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), {16'd0, observed()}, {16'd0, expect_vec(ph[i], ex, o, f, r)});
      if (i == abort_at) begin
        reset = 1'b0;
        #1;
        check($sformatf("%s_abort_en", name), {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
        m_flags = '0;
        return;
      end
      if (ph[i] == P_EX && ex && f[0]) begin
        m_flags[3:2] = af[3:2];
        if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010) m_flags[1:0] = af[1:0];
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = '0; Rd = '0; ALUFlags = '0;
    do_reset();

    run_instr("add_imm",  4'hE, 2'b00, 6'b101000, 4'd1,  1'b1, 4'b0000, -1);
    run_instr("subs_z",   4'hE, 2'b00, 6'b100101, 4'd2,  1'b1, 4'b0100, -1);
    run_instr("addeq_t",  4'h0, 2'b00, 6'b101000, 4'd1,  1'b1, 4'b0000, -1);
    run_instr("subs_nz",  4'hE, 2'b00, 6'b100101, 4'd2,  1'b1, 4'b0000, -1);
    run_instr("addeq_f",  4'h0, 2'b00, 6'b101000, 4'd1,  1'b1, 4'b0000, -1);
    run_instr("ldr",      4'hE, 2'b01, 6'b011001, 4'd3,  1'b1, 4'b0000, -1);
    run_instr("str",      4'hE, 2'b01, 6'b011000, 4'd3,  1'b1, 4'b0000, -1);
    run_instr("subs_z2",  4'hE, 2'b00, 6'b100101, 4'd2,  1'b1, 4'b0100, -1);
    run_instr("bne_nt",   4'h1, 2'b10, 6'b000000, 4'd0,  1'b1, 4'b0000, -1);
    run_instr("subs_nz2", 4'hE, 2'b00, 6'b100101, 4'd2,  1'b1, 4'b0000, -1);
    run_instr("bne_t",    4'h1, 2'b10, 6'b000000, 4'd0,  1'b1, 4'b0000, -1);
    run_instr("undef",    4'hE, 2'b11, 6'b111111, 4'd15, 1'b1, 4'b0000, -1);
    run_instr("add_nv",   4'hF, 2'b00, 6'b001000, 4'd1,  1'b1, 4'b0000, -1);
    run_instr("add_pc",   4'hE, 2'b00, 6'b001000, 4'd15, 1'b1, 4'b0000, -1);
    run_instr("orr_reg",  4'hE, 2'b00, 6'b011000, 4'd4,  1'b1, 4'b0000, -1);
    run_instr("and_reg",  4'hE, 2'b00, 6'b000001, 4'd5,  1'b1, 4'b1111, -1);

    run_instr("subs_z3",  4'hE, 2'b00, 6'b100101, 4'd2,  1'b1, 4'b0100, -1);
    run_instr("str_abort", 4'hE, 2'b01, 6'b011000, 4'd3, 1'b1, 4'b0000, 3);
    do_reset();
    run_instr("addeq_rst", 4'h0, 2'b00, 6'b101000, 4'd1, 1'b1, 4'b0000, -1);

    for (int i = 0; i < 300; i++) begin
      logic [3:0] rc, rr;
      logic [1:0] ro;
      logic [5:0] rf;
      rc = 4'($urandom);
      ro = 2'($urandom);
      rf = 6'($urandom);
      rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr($sformatf("rnd%0d", i), rc, ro, rf, rr, 1'b0, 4'b0000, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
